// File: rtl/hazard_noop_ctrl_if.sv
// Bundle between the ID stage and the hazard controller. The pipeline side
// (master) drives the decode/ID-EX view. The controller (slave) returns the
// bubble, freeze and flush controls plus the performance counters.
interface hazard_noop_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [6:0]       opcode_i;
   logic [4:0]       rs1_addr_i;
   logic [4:0]       rs2_addr_i;
   logic             idex_memread_i;
   logic [4:0]       idex_rd_i;
   logic             branch_taken_i;
   logic             no_op_o;
   logic             pc_write_o;
   logic             ifid_write_o;
   logic             flush_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport master (
      output opcode_i, rs1_addr_i, rs2_addr_i, idex_memread_i, idex_rd_i, branch_taken_i,
      input  no_op_o, pc_write_o, ifid_write_o, flush_o, stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  opcode_i, rs1_addr_i, rs2_addr_i, idex_memread_i, idex_rd_i, branch_taken_i,
      output no_op_o, pc_write_o, ifid_write_o, flush_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/hazard_noop_ctrl.sv
// ID-stage hazard controller. It detects load-use hazards and taken branches.
// It inserts LOAD_LAT bubbles per hazard, freezes the PC and IF/ID, and flushes
// IF/ID on a taken branch. It also keeps saturating stall and flush counters.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | normal flow; a hazard bubbles this cycle, a taken branch flushes
// STALL | extra bubbles for slow loads; cnt counts the bubbles still owed
module hazard_noop_ctrl #(
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input logic               clk_i,
   input logic               rst_i,
   hazard_noop_ctrl_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

   // The first bubble comes from IDLE itself, so STALL covers the other LOAD_LAT-1 bubbles.
   localparam logic [3:0]       CNT_INIT = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state, state_nxt;
   logic [3:0]       cnt, cnt_nxt;
   logic             uses_rs1, uses_rs2, hazard;
   logic             no_op, pc_write, ifid_write, flush;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   // Decode which source registers the ID-stage instruction actually reads.
   always_comb begin
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      case (bus.opcode_i)
         7'b0110011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         7'b0010011: uses_rs1 = 1'b1;
         7'b0000011: uses_rs1 = 1'b1;
         7'b0100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         7'b1100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         default:    ;
      endcase
   end

   assign hazard = bus.idex_memread_i && (bus.idex_rd_i != 5'd0) &&
                   ((uses_rs1 && (bus.idex_rd_i == bus.rs1_addr_i)) ||
                    (uses_rs2 && (bus.idex_rd_i == bus.rs2_addr_i)));

   // State register and stall down-counter.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic. STALL ignores the hazard input because the bubble already sits in EX.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (hazard && (LOAD_LAT > 1)) begin
               state_nxt = STALL;
               cnt_nxt   = CNT_INIT;
            end
         end
         STALL: begin
            if (cnt == 4'd0) state_nxt = IDLE;
            else             cnt_nxt   = cnt - 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic. The default is a full bubble; only a hazard-free IDLE cycle lets the pipe advance.
   // A stall beats a taken branch: the branch operands are not ready, so the branch re-resolves later.
   always_comb begin
      no_op      = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      flush      = 1'b0;
      if (rst_i && (state == IDLE) && !hazard) begin
         no_op      = 1'b0;
         pc_write   = 1'b1;
         ifid_write = 1'b1;
         flush      = bus.branch_taken_i;
      end
   end

   // Saturating performance counters. No counting is done while reset is held.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (no_op && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
         if (flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign bus.no_op_o      = no_op;
   assign bus.pc_write_o   = pc_write;
   assign bus.ifid_write_o = ifid_write;
   assign bus.flush_o      = flush;
   assign bus.stall_cnt_o  = stall_cnt;
   assign bus.flush_cnt_o  = flush_cnt;

endmodule

// File: tb/tb_hazard_noop_ctrl.sv
// Directed bench for hazard_noop_ctrl. It uses three instances:
// u1 (LOAD_LAT=1), u3 (LOAD_LAT=3) and u4 (LOAD_LAT=3, CNT_W=4).
// The control outputs are compared as one 4-bit vector {no_op, pc_write, ifid_write, flush}.
module tb_hazard_noop_ctrl;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   localparam logic [3:0] CTL_BUBBLE = 4'b1000;
   localparam logic [3:0] CTL_RUN    = 4'b0110;
   localparam logic [3:0] CTL_FLUSH  = 4'b0111;

   logic clk = 1'b0;
   logic rst1, rst3, rst4;
   int   checks   = 0;
   int   failures = 0;

   hazard_noop_ctrl_if #(.CNT_W(16)) if1 ();
   hazard_noop_ctrl_if #(.CNT_W(16)) if3 ();
   hazard_noop_ctrl_if #(.CNT_W(4))  if4 ();

   hazard_noop_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u1 (.clk_i(clk), .rst_i(rst1), .bus(if1));
   hazard_noop_ctrl #(.LOAD_LAT(3), .CNT_W(16)) u3 (.clk_i(clk), .rst_i(rst3), .bus(if3));
   hazard_noop_ctrl #(.LOAD_LAT(3), .CNT_W(4))  u4 (.clk_i(clk), .rst_i(rst4), .bus(if4));

   always #5 clk = ~clk;

   wire [3:0] ctl1 = {if1.no_op_o, if1.pc_write_o, if1.ifid_write_o, if1.flush_o};
   wire [3:0] ctl3 = {if3.no_op_o, if3.pc_write_o, if3.ifid_write_o, if3.flush_o};
   wire [3:0] ctl4 = {if4.no_op_o, if4.pc_write_o, if4.ifid_write_o, if4.flush_o};

   task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic mr, input logic [4:0] rd, input logic br);
      if1.opcode_i = op; if1.rs1_addr_i = rs1; if1.rs2_addr_i = rs2;
      if1.idex_memread_i = mr; if1.idex_rd_i = rd; if1.branch_taken_i = br;
      if3.opcode_i = op; if3.rs1_addr_i = rs1; if3.rs2_addr_i = rs2;
      if3.idex_memread_i = mr; if3.idex_rd_i = rd; if3.branch_taken_i = br;
      if4.opcode_i = op; if4.rs1_addr_i = rs1; if4.rs2_addr_i = rs2;
      if4.idex_memread_i = mr; if4.idex_rd_i = rd; if4.branch_taken_i = br;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
      drive(OP_R, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
   endtask

   task automatic test_reset();
      rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
      drive(OP_BR, 5'd5, 5'd6, 1'b0, 5'd0, 1'b1);
      @(negedge clk); @(negedge clk);
      checks++;
      if (ctl1 !== CTL_BUBBLE) begin failures++; $display("FAIL reset_ctl1 got=%b exp=%b", ctl1, CTL_BUBBLE); end
      checks++;
      if (ctl4 !== CTL_BUBBLE) begin failures++; $display("FAIL reset_ctl4 got=%b exp=%b", ctl4, CTL_BUBBLE); end
      checks++;
      if (if1.stall_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", if1.stall_cnt_o); end
      checks++;
      if (if1.flush_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_flush_cnt got=%0d exp=0", if1.flush_cnt_o); end
      apply_reset();
   endtask

   task automatic test_lat1();
      apply_reset();
      drive(OP_R, 5'd5, 5'd6, 1'b1, 5'd5, 1'b0);
      #1;
      checks++;
      if (ctl1 !== CTL_BUBBLE) begin failures++; $display("FAIL lat1_hazard got=%b exp=%b", ctl1, CTL_BUBBLE); end
      @(negedge clk);
      drive(OP_R, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      #1;
      checks++;
      if (ctl1 !== CTL_RUN) begin failures++; $display("FAIL lat1_release got=%b exp=%b", ctl1, CTL_RUN); end
      checks++;
      if (if1.stall_cnt_o !== 16'd1) begin failures++; $display("FAIL lat1_stall_cnt got=%0d exp=1", if1.stall_cnt_o); end
      @(negedge clk);
      drive(OP_ST, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0);
      #1;
      checks++;
      if (ctl1 !== CTL_BUBBLE) begin failures++; $display("FAIL lat1_rs2_hazard got=%b exp=%b", ctl1, CTL_BUBBLE); end
      @(negedge clk);
      drive(OP_R, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      #1;
      checks++;
      if (if1.stall_cnt_o !== 16'd2) begin failures++; $display("FAIL lat1_stall_cnt2 got=%0d exp=2", if1.stall_cnt_o); end
   endtask

   task automatic test_lat3();
      apply_reset();
      drive(OP_R, 5'd5, 5'd6, 1'b1, 5'd5, 1'b0);
      #1;
      checks++;
      if (ctl3 !== CTL_BUBBLE) begin failures++; $display("FAIL lat3_c1 got=%b exp=%b", ctl3, CTL_BUBBLE); end
      for (int c = 2; c <= 3; c++) begin
         @(negedge clk);
         drive(OP_BR, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1);
         #1;
         checks++;
         if (ctl3 !== CTL_BUBBLE) begin failures++; $display("FAIL lat3_c%0d got=%b exp=%b", c, ctl3, CTL_BUBBLE); end
      end
      @(negedge clk);
      drive(OP_R, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      #1;
      checks++;
      if (ctl3 !== CTL_RUN) begin failures++; $display("FAIL lat3_release got=%b exp=%b", ctl3, CTL_RUN); end
      checks++;
      if (if3.stall_cnt_o !== 16'd3) begin failures++; $display("FAIL lat3_stall_cnt got=%0d exp=3", if3.stall_cnt_o); end
      checks++;
      if (if3.flush_cnt_o !== 16'd0) begin failures++; $display("FAIL lat3_flush_cnt got=%0d exp=0", if3.flush_cnt_o); end
   endtask

   task automatic test_no_hazard();
      logic [6:0] ops [4] = '{OP_R, OP_I, OP_LUI, OP_R};
      logic [4:0] rs1 [4] = '{5'd0, 5'd3, 5'd5, 5'd5};
      logic [4:0] rs2 [4] = '{5'd0, 5'd5, 5'd5, 5'd5};
      logic       mr  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [4:0] rd  [4] = '{5'd0, 5'd5, 5'd5, 5'd5};
      apply_reset();
      for (int v = 0; v < 4; v++) begin
         drive(ops[v], rs1[v], rs2[v], mr[v], rd[v], 1'b0);
         #1;
         checks++;
         if (ctl1 !== CTL_RUN) begin failures++; $display("FAIL nohaz_u1_v%0d got=%b exp=%b", v, ctl1, CTL_RUN); end
         checks++;
         if (ctl3 !== CTL_RUN) begin failures++; $display("FAIL nohaz_u3_v%0d got=%b exp=%b", v, ctl3, CTL_RUN); end
         @(negedge clk);
      end
      checks++;
      if (if3.stall_cnt_o !== 16'd0) begin failures++; $display("FAIL nohaz_stall_cnt got=%0d exp=0", if3.stall_cnt_o); end
   endtask

   task automatic test_branch();
      apply_reset();
      drive(OP_BR, 5'd5, 5'd6, 1'b1, 5'd5, 1'b1);
      #1;
      checks++;
      if (ctl1 !== CTL_BUBBLE) begin failures++; $display("FAIL br_hazard got=%b exp=%b", ctl1, CTL_BUBBLE); end
      @(negedge clk);
      drive(OP_BR, 5'd5, 5'd6, 1'b0, 5'd0, 1'b1);
      #1;
      checks++;
      if (ctl1 !== CTL_FLUSH) begin failures++; $display("FAIL br_flush got=%b exp=%b", ctl1, CTL_FLUSH); end
      @(negedge clk);
      drive(OP_R, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      #1;
      checks++;
      if (if1.flush_cnt_o !== 16'd1) begin failures++; $display("FAIL br_flush_cnt got=%0d exp=1", if1.flush_cnt_o); end
      checks++;
      if (if1.stall_cnt_o !== 16'd1) begin failures++; $display("FAIL br_stall_cnt got=%0d exp=1", if1.stall_cnt_o); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int c = 1; c <= 6; c++) begin
         drive(OP_R, 5'd7, 5'd2, 1'b1, 5'd7, 1'b0);
         #1;
         checks++;
         if (if3.no_op_o !== 1'b1) begin failures++; $display("FAIL b2b_c%0d no_op got=%b exp=1", c, if3.no_op_o); end
         @(negedge clk);
      end
      drive(OP_R, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      #1;
      checks++;
      if (ctl3 !== CTL_RUN) begin failures++; $display("FAIL b2b_release got=%b exp=%b", ctl3, CTL_RUN); end
      checks++;
      if (if3.stall_cnt_o !== 16'd6) begin failures++; $display("FAIL b2b_stall_cnt got=%0d exp=6", if3.stall_cnt_o); end
   endtask

   task automatic test_saturate_reset();
      apply_reset();
      for (int c = 1; c <= 22; c++) begin
         drive(OP_R, 5'd9, 5'd2, 1'b1, 5'd9, 1'b0);
         #1;
         checks++;
         if (if4.no_op_o !== 1'b1) begin failures++; $display("FAIL sat_c%0d no_op got=%b exp=1", c, if4.no_op_o); end
         @(negedge clk);
      end
      // Cycle 23: u4 is in STALL and still owes two bubbles.
      drive(OP_BR, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1);
      #1;
      checks++;
      if (if4.stall_cnt_o !== 4'd15) begin failures++; $display("FAIL sat_stall_cnt got=%0d exp=15", if4.stall_cnt_o); end
      rst4 = 1'b0;
      #1;
      checks++;
      if (ctl4 !== CTL_BUBBLE) begin failures++; $display("FAIL sat_rst_forced got=%b exp=%b", ctl4, CTL_BUBBLE); end
      @(negedge clk);
      checks++;
      if (if4.stall_cnt_o !== 4'd0) begin failures++; $display("FAIL sat_rst_stall_cnt got=%0d exp=0", if4.stall_cnt_o); end
      checks++;
      if (if4.flush_cnt_o !== 4'd0) begin failures++; $display("FAIL sat_rst_flush_cnt got=%0d exp=0", if4.flush_cnt_o); end
      rst4 = 1'b1;
      drive(OP_R, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
      #1;
      checks++;
      if (ctl4 !== CTL_RUN) begin failures++; $display("FAIL sat_after_rst got=%b exp=%b", ctl4, CTL_RUN); end
   endtask

   initial begin
      test_reset();
      test_lat1();
      test_lat3();
      test_no_hazard();
      test_branch();
      test_back_to_back();
      test_saturate_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
